// File: rtl/vga_timing_pkg.sv
// ------------------------------------------------------------------
// vga_timing_pkg: default VGA timing constants, derived-timing helpers, FSM types
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_RD_LEAD  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } main_state_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DONE = 2'd2
  } fetch_state_t;

  function automatic int line_total(int sync, int bp, int act, int fp);
    return sync + bp + act + fp;
  endfunction

  function automatic int act_start(int sync, int bp);
    return sync + bp;
  endfunction

  function automatic int act_end(int sync, int bp, int act);
    return sync + bp + act;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_read_scheduler_if.sv
// ------------------------------------------------------------------
// vga_read_scheduler_if: line-fetch handshake between scheduler and line buffer
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

interface vga_read_scheduler_if;
  import vga_timing_pkg::*;

  logic             LINE_FETCH_REQ;
  logic [CNT_W-1:0] LINE_FETCH_Y;
  logic             LINE_FETCH_ACK;

  modport master (output LINE_FETCH_REQ, output LINE_FETCH_Y, input  LINE_FETCH_ACK);
  modport slave  (input  LINE_FETCH_REQ, input  LINE_FETCH_Y, output LINE_FETCH_ACK);
endinterface

`default_nettype wire

// File: rtl/vga_line_fetch_ctrl.sv
// ------------------------------------------------------------------
// vga_line_fetch_ctrl: one-line-ahead fetch request FSM and sticky underrun flag
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module vga_line_fetch_ctrl
  import vga_timing_pkg::*;
#(
  parameter int V_ACT_START = DEF_V_SYNC + DEF_V_BP,
  parameter int V_ACT_END   = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [CNT_W-1:0] h_i,
  input  logic [CNT_W-1:0] v_i,
  input  logic             rd_rise_i,
  input  logic             ack_i,
  output logic             req_o,
  output logic [CNT_W-1:0] y_o,
  output logic             underrun_o
);

  localparam logic [CNT_W-1:0] ROW_BASE   = CNT_W'(V_ACT_START - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(V_ACT_END - 1);

  fetch_state_t     state_q;
  logic             req_q;
  logic [CNT_W-1:0] y_q;
  logic             ready_q;
  logic             underrun_q;

  logic w_line_start;
  logic w_frame_start;
  logic w_next_active;
  logic w_acked;

  assign w_line_start  = (h_i == '0);
  assign w_frame_start = w_line_start && (v_i == '0);
  assign w_next_active = (v_i >= ROW_BASE) && (v_i < FETCH_LAST);
  assign w_acked       = (state_q == F_REQ) && ack_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= F_IDLE;
      req_q      <= 1'b0;
      y_q        <= '0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else if (!run_i) begin
      state_q    <= F_IDLE;
      req_q      <= 1'b0;
      y_q        <= '0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= (underrun_q && !w_frame_start) || (rd_rise_i && !ready_q);
      if (w_line_start) begin
        // The line just finished fetched the row now being shown; a stale
        // request is dropped here and the next row is requested immediately.
        ready_q <= w_acked || (state_q == F_DONE);
        if (w_next_active) begin
          state_q <= F_REQ;
          req_q   <= 1'b1;
          y_q     <= v_i - ROW_BASE;
        end else begin
          state_q <= F_IDLE;
          req_q   <= 1'b0;
        end
      end else if (w_acked) begin
        state_q <= F_DONE;
        req_q   <= 1'b0;
      end
    end
  end

  assign req_o      = req_q;
  assign y_o        = y_q;
  assign underrun_o = underrun_q;

endmodule

`default_nettype wire

// File: rtl/vga_read_scheduler.sv
// ------------------------------------------------------------------
// vga_read_scheduler: VGA sync/DE timing, FIFO read window and line-fetch sequencing
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module vga_read_scheduler
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int RD_LEAD  = DEF_RD_LEAD
) (
  input  logic                 VGA_CLK,
  input  logic                 RESET_N,
  input  logic                 ENABLE,
  vga_read_scheduler_if.master fetch_if,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 READ_Request,
  output logic                 VGA_DE,
  output logic                 FRAME_START,
  output logic                 UNDERRUN
);

  localparam int H_TOTAL = line_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = line_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int A_START = act_start(H_SYNC, H_BP);
  localparam int A_END   = act_end(H_SYNC, H_BP, H_ACTIVE);
  localparam int VA_S    = act_start(V_SYNC, V_BP);
  localparam int VA_E    = act_end(V_SYNC, V_BP, V_ACTIVE);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] RR_START = CNT_W'(A_START - RD_LEAD);
  localparam logic [CNT_W-1:0] RR_END   = CNT_W'(A_END - RD_LEAD);
  localparam logic [CNT_W-1:0] VA_START = CNT_W'(VA_S);
  localparam logic [CNT_W-1:0] VA_END   = CNT_W'(VA_E);

  main_state_t      state_q;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;
  logic             hs_q;
  logic             vs_q;
  logic             rr_q;
  logic             fs_q;
  logic [RD_LEAD-1:0] de_sr_q;

  logic             w_v_act;
  logic             w_rr;
  logic             w_rd_rise;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_run;
  logic [RD_LEAD:0] w_de_shift;

  assign w_v_act    = (v_q >= VA_START) && (v_q < VA_END);
  assign w_rr       = w_v_act && (h_q >= RR_START) && (h_q < RR_END);
  assign w_rd_rise  = w_v_act && (h_q == RR_START);
  assign w_h_wrap   = (h_q == H_LAST);
  assign w_v_wrap   = (v_q == V_LAST);
  assign w_run      = (state_q == RUN);
  assign w_de_shift = {de_sr_q, rr_q};

  // Every output register samples the counters, so outputs lag them by one cycle.
  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rr_q    <= 1'b0;
      fs_q    <= 1'b0;
      de_sr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          h_q     <= '0;
          v_q     <= '0;
          hs_q    <= 1'b1;
          vs_q    <= 1'b1;
          rr_q    <= 1'b0;
          fs_q    <= 1'b0;
          de_sr_q <= '0;
          if (ENABLE) state_q <= RUN;
        end
        RUN: begin
          hs_q    <= (h_q >= HS_END);
          vs_q    <= (v_q >= VS_END);
          rr_q    <= w_rr;
          fs_q    <= (h_q == '0) && (v_q == '0);
          de_sr_q <= w_de_shift[RD_LEAD-1:0];
          if (w_h_wrap) begin
            h_q <= '0;
            if (w_v_wrap) begin
              v_q <= '0;
              if (!ENABLE) state_q <= IDLE;
            end else begin
              v_q <= v_q + 1'b1;
            end
          end else begin
            h_q <= h_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  vga_line_fetch_ctrl #(
    .V_ACT_START (VA_S),
    .V_ACT_END   (VA_E)
  ) u_fetch (
    .clk_i      (VGA_CLK),
    .rst_ni     (RESET_N),
    .run_i      (w_run),
    .h_i        (h_q),
    .v_i        (v_q),
    .rd_rise_i  (w_rd_rise),
    .ack_i      (fetch_if.LINE_FETCH_ACK),
    .req_o      (fetch_if.LINE_FETCH_REQ),
    .y_o        (fetch_if.LINE_FETCH_Y),
    .underrun_o (UNDERRUN)
  );

  assign VGA_HS       = hs_q;
  assign VGA_VS       = vs_q;
  assign READ_Request = rr_q;
  assign VGA_DE       = de_sr_q[RD_LEAD-1];
  assign FRAME_START  = fs_q;

endmodule

`default_nettype wire
